// File: rtl/spi_access_scheduler_pkg.sv
// Shared definitions for the SPI access scheduler: FSM state encoding,
// grant identifiers, R/W encoding, result constants and the poll address helper.
package spi_access_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_HOLDOFF  = 3'd0,
    ST_IDLE     = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT     = 3'd3,
    ST_COMPLETE = 3'd4
  } sched_state_t;

  localparam logic GRANT_HOST = 1'b0;
  localparam logic GRANT_POLL = 1'b1;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Value reported when the engine never answers.
  localparam logic [7:0] ABORT_DATA = 8'hFF;
  // Value reported back to the host for a completed write.
  localparam logic [7:0] WRITE_RDATA = 8'h00;

  // Polled register address: base plus index, wrapping modulo 128.
  function automatic logic [6:0] poll_addr_of(input logic [6:0] base, input logic [3:0] idx);
    return base + {3'b000, idx};
  endfunction

endpackage

// File: rtl/spi_access_scheduler_poll_seq.sv
// spi_poll_seq: auto-poll request generator for the SPI access scheduler.
// Holds the free-running interval counter, the poll index, the pending
// request flag and the sticky overrun flag. Only instantiated when
// SPI_SCHED_POLL_EN is defined.
module spi_poll_seq
  import spi_access_scheduler_pkg::*;
#(
  parameter logic [6:0] POLL_BASE     = 7'h00,
  parameter int         POLL_COUNT    = 4,
  parameter int         POLL_INTERVAL = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       poll_done,
  output logic       poll_req,
  output logic [6:0] poll_addr,
  output logic       overrun
);

  localparam int IW = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [IW-1:0] IVL_LAST = IW'(POLL_INTERVAL - 1);
  localparam logic [3:0]    IDX_LAST = 4'(POLL_COUNT - 1);

  logic [IW-1:0] ivl_cnt;
  logic [3:0]    idx;
  logic          pend;
  logic          expire;

  // The expiring cycle already counts as a request so a same-cycle host
  // start sees a genuine tie in IDLE.
  assign expire    = (ivl_cnt == IVL_LAST);
  assign poll_req  = pend | expire;
  assign poll_addr = poll_addr_of(POLL_BASE, idx);

  // Interval counter, pending flag, overrun flag and index advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      ivl_cnt <= '0;
      idx     <= 4'd0;
      pend    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (expire) begin
        ivl_cnt <= '0;
      end else begin
        ivl_cnt <= ivl_cnt + IW'(1);
      end
      pend <= (pend & ~poll_done) | expire;
      if (expire && pend && !poll_done) begin
        overrun <= 1'b1;
      end
      if (poll_done) begin
        if (idx == IDX_LAST) begin
          idx <= 4'd0;
        end else begin
          idx <= idx + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_access_scheduler.sv
// spi_access_scheduler: arbitrates host and auto-poll register requests onto
// the bit-banged SPI engine, waits for the engine's done pulse with a timeout
// and returns read data to the granted requester.
// Optional feature macro: SPI_SCHED_POLL_EN (auto-poll sequencer present).
module spi_access_scheduler
  import spi_access_scheduler_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 255,
  parameter int         HOLDOFF_CYCLES = 64,
  parameter logic [6:0] POLL_BASE      = 7'h00,
  parameter int         POLL_COUNT     = 4,
  parameter int         POLL_INTERVAL  = 50000
) (
  input  logic       FSM_Clk,
  input  logic       Reset,
  input  logic       Host_Start,
  input  logic       Host_R_W,
  input  logic [6:0] Host_Addr,
  input  logic [7:0] Host_WData,
  output logic       Host_Busy,
  output logic       Host_Done,
  output logic [7:0] Host_RData,
  output logic       Poll_Valid,
  output logic [6:0] Poll_Addr,
  output logic [7:0] Poll_Data,
  output logic       ENG_Trigger,
  output logic       ENG_R_W,
  output logic [6:0] ENG_Addr,
  output logic [7:0] ENG_WData,
  input  logic [7:0] ENG_RData,
  input  logic       ENG_Done,
  output logic       Timeout_Err,
  output logic       Timeout_Flag,
  output logic       Poll_Overrun
);

  if (POLL_COUNT < 1 || POLL_COUNT > 16 || POLL_INTERVAL < 2 ||
      TIMEOUT_CYCLES < 1 || HOLDOFF_CYCLES < 1) begin : g_bad_cfg
    $error("spi_access_scheduler: unsupported parameter set");
  end

  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  sched_state_t state;
  logic [15:0]  hold_cnt;
  logic [15:0]  wait_cnt;
  logic         grant;

  // Latched host request; host_pend doubles as the busy indication.
  logic         host_pend;
  logic         h_rw;
  logic [6:0]   h_addr;
  logic [7:0]   h_wdata;

  logic         host_acc_s;
  logic         host_req_s;
  logic         host_rw_s;
  logic [6:0]   host_addr_s;
  logic [7:0]   host_wdata_s;
  logic [7:0]   result_s;

  assign Host_Busy    = host_pend;
  assign host_acc_s   = Host_Start & ~host_pend;
  assign host_req_s   = host_pend | host_acc_s;
  // A request arriving in IDLE is served the same cycle from the live inputs.
  assign host_rw_s    = host_pend ? h_rw    : Host_R_W;
  assign host_addr_s  = host_pend ? h_addr  : Host_Addr;
  assign host_wdata_s = host_pend ? h_wdata : Host_WData;

`ifdef SPI_SCHED_POLL_EN
  logic       last_grant;
  logic       poll_req_s;
  logic [6:0] poll_addr_s;
  logic       poll_done_s;
  logic       pick_poll_s;

  assign poll_done_s = (state == ST_COMPLETE) && (grant == GRANT_POLL);

  spi_poll_seq #(
    .POLL_BASE     (POLL_BASE),
    .POLL_COUNT    (POLL_COUNT),
    .POLL_INTERVAL (POLL_INTERVAL)
  ) u_poll_seq (
    .clk       (FSM_Clk),
    .reset     (Reset),
    .poll_done (poll_done_s),
    .poll_req  (poll_req_s),
    .poll_addr (poll_addr_s),
    .overrun   (Poll_Overrun)
  );

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    pick_poll_s = 1'b0;
    if (poll_req_s && host_req_s) begin
      pick_poll_s = (last_grant == GRANT_HOST);
    end else if (poll_req_s) begin
      pick_poll_s = 1'b1;
    end else begin
      pick_poll_s = 1'b0;
    end
  end
`else
  assign Poll_Valid   = 1'b0;
  assign Poll_Overrun = 1'b0;
  assign Poll_Addr    = POLL_BASE;
  assign Poll_Data    = 8'h00;
`endif

  // Result of the WAIT state: engine data, write acknowledge or abort value.
  always_comb begin
    result_s = ABORT_DATA;
    if (ENG_Done) begin
      if (ENG_R_W == RW_WRITE) begin
        result_s = WRITE_RDATA;
      end else begin
        result_s = ENG_RData;
      end
    end else begin
      result_s = ABORT_DATA;
    end
  end

  // Main sequencing FSM with all registered outputs.
  always_ff @(posedge FSM_Clk) begin
    if (Reset) begin
      state        <= ST_HOLDOFF;
      hold_cnt     <= 16'd0;
      wait_cnt     <= 16'd0;
      grant        <= GRANT_HOST;
      host_pend    <= 1'b0;
      h_rw         <= RW_READ;
      h_addr       <= 7'h00;
      h_wdata      <= 8'h00;
      Host_Done    <= 1'b0;
      Host_RData   <= 8'h00;
      ENG_Trigger  <= 1'b0;
      ENG_R_W      <= RW_READ;
      ENG_Addr     <= 7'h00;
      ENG_WData    <= 8'h00;
      Timeout_Err  <= 1'b0;
      Timeout_Flag <= 1'b0;
`ifdef SPI_SCHED_POLL_EN
      last_grant   <= GRANT_POLL;
      Poll_Valid   <= 1'b0;
      Poll_Addr    <= POLL_BASE;
      Poll_Data    <= 8'h00;
`endif
    end else begin
      Host_Done   <= 1'b0;
      ENG_Trigger <= 1'b0;
      Timeout_Err <= 1'b0;
`ifdef SPI_SCHED_POLL_EN
      Poll_Valid  <= 1'b0;
`endif
      if (host_acc_s) begin
        host_pend <= 1'b1;
        h_rw      <= Host_R_W;
        h_addr    <= Host_Addr;
        h_wdata   <= Host_WData;
      end

      case (state)
        ST_HOLDOFF: begin
          // Lets an engine transaction cut off by reset run to completion.
          if (hold_cnt == HOLD_LAST) begin
            state <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        ST_IDLE: begin
`ifdef SPI_SCHED_POLL_EN
          if (pick_poll_s) begin
            grant       <= GRANT_POLL;
            ENG_R_W     <= RW_READ;
            ENG_Addr    <= poll_addr_s;
            ENG_WData   <= 8'h00;
            ENG_Trigger <= 1'b1;
            state       <= ST_ISSUE;
          end else
`endif
          if (host_req_s) begin
            grant       <= GRANT_HOST;
            ENG_R_W     <= host_rw_s;
            ENG_Addr    <= host_addr_s;
            ENG_WData   <= host_wdata_s;
            ENG_Trigger <= 1'b1;
            state       <= ST_ISSUE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= 16'd0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ENG_Done || (wait_cnt == WAIT_LAST)) begin
            state <= ST_COMPLETE;
            if (!ENG_Done) begin
              Timeout_Err  <= 1'b1;
              Timeout_Flag <= 1'b1;
            end
            if (grant == GRANT_HOST) begin
              Host_Done  <= 1'b1;
              Host_RData <= result_s;
            end
`ifdef SPI_SCHED_POLL_EN
            else begin
              Poll_Valid <= 1'b1;
              Poll_Addr  <= ENG_Addr;
              Poll_Data  <= result_s;
            end
`endif
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_COMPLETE: begin
          if (grant == GRANT_HOST) begin
            host_pend <= 1'b0;
          end
`ifdef SPI_SCHED_POLL_EN
          last_grant <= grant;
`endif
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_HOLDOFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_access_scheduler.sv
// Self-checking bench for spi_access_scheduler. Host transactions are checked
// against expectations computed from the scheduling rules (latency, timeout,
// busy window, result data); poll tests run only when SPI_SCHED_POLL_EN is set.
module tb_spi_access_scheduler;

  localparam int         TB_TIMEOUT  = 255;
  localparam int         TB_HOLDOFF  = 64;
  localparam logic [6:0] TB_BASE     = 7'h7E;
  localparam int         TB_COUNT    = 4;
  localparam int         TB_INTERVAL = 300;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Host_Start = 1'b0;
  logic       Host_R_W = 1'b0;
  logic [6:0] Host_Addr = 7'h00;
  logic [7:0] Host_WData = 8'h00;
  logic       Host_Busy, Host_Done;
  logic [7:0] Host_RData;
  logic       Poll_Valid;
  logic [6:0] Poll_Addr;
  logic [7:0] Poll_Data;
  logic       ENG_Trigger, ENG_R_W;
  logic [6:0] ENG_Addr;
  logic [7:0] ENG_WData;
  logic [7:0] ENG_RData = 8'h00;
  logic       ENG_Done = 1'b0;
  logic       Timeout_Err, Timeout_Flag, Poll_Overrun;

  int vectors = 0;
  int miscompares = 0;
  logic exp_flag = 1'b0;

  always #5 clk = ~clk;

  spi_access_scheduler #(
    .TIMEOUT_CYCLES (TB_TIMEOUT),
    .HOLDOFF_CYCLES (TB_HOLDOFF),
    .POLL_BASE      (TB_BASE),
    .POLL_COUNT     (TB_COUNT),
    .POLL_INTERVAL  (TB_INTERVAL)
  ) dut (
    .FSM_Clk (clk), .Reset (Reset),
    .Host_Start (Host_Start), .Host_R_W (Host_R_W), .Host_Addr (Host_Addr),
    .Host_WData (Host_WData), .Host_Busy (Host_Busy), .Host_Done (Host_Done),
    .Host_RData (Host_RData), .Poll_Valid (Poll_Valid), .Poll_Addr (Poll_Addr),
    .Poll_Data (Poll_Data), .ENG_Trigger (ENG_Trigger), .ENG_R_W (ENG_R_W),
    .ENG_Addr (ENG_Addr), .ENG_WData (ENG_WData), .ENG_RData (ENG_RData),
    .ENG_Done (ENG_Done), .Timeout_Err (Timeout_Err), .Timeout_Flag (Timeout_Flag),
    .Poll_Overrun (Poll_Overrun)
  );

  function automatic logic [45:0] obs_vec();
    return {Host_Busy, Host_Done, Host_RData, Poll_Valid, Poll_Addr, Poll_Data,
            ENG_Trigger, ENG_R_W, ENG_Addr, ENG_WData, Timeout_Err, Timeout_Flag,
            Poll_Overrun};
  endfunction

  function automatic logic [45:0] reset_vec();
    return {1'b0, 1'b0, 8'h00, 1'b0, TB_BASE, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00,
            1'b0, 1'b0, 1'b0};
  endfunction

  // One host transaction. Cycle c=0 is the Host_Start cycle (Reset is also
  // released there). Engine answers k cycles into WAIT; k >= timeout means never.
  task automatic run_txn(input string name, input logic rw, input logic [6:0] addr,
                         input logic [7:0] wd, input int k, input logic [7:0] rd,
                         input int exp_trig, input bit poke, input bit stray);
    int exp_done;
    logic [7:0] exp_rd;
    bit exp_to;
    int trig_cnt = 0, trig_c = -1, done_cnt = 0, done_c = -1;
    int err_cnt = 0, err_c = -1, busy_bad = 0;
    logic [7:0] rw_addr_at_trig = 8'h00;
    logic [7:0] wd_at_trig = 8'h00;
    logic [7:0] rd_at_done = 8'h00;
    exp_to   = (k >= TB_TIMEOUT);
    exp_done = exp_to ? (exp_trig + 1 + TB_TIMEOUT) : (exp_trig + 2 + k);
    exp_rd   = exp_to ? 8'hFF : (rw ? 8'h00 : rd);
    if (exp_to) exp_flag = 1'b1;
    for (int c = 0; c <= exp_done + 2; c++) begin
      @(negedge clk);
      if (ENG_Trigger) begin
        trig_cnt++;
        if (trig_c < 0) begin
          trig_c = c;
          rw_addr_at_trig = {ENG_R_W, ENG_Addr};
          wd_at_trig = ENG_WData;
        end
      end
      if (Host_Done) begin
        done_cnt++;
        if (done_c < 0) begin
          done_c = c;
          rd_at_done = Host_RData;
        end
      end
      if (Timeout_Err) begin
        err_cnt++;
        err_c = c;
      end
      if (Host_Busy !== ((c >= 1) && (c <= exp_done))) busy_bad++;
      Reset = 1'b0;
      Host_Start = 1'b0;
      ENG_Done = 1'b0;
      ENG_RData = 8'($urandom);
      if (c == 0) begin
        Host_Start = 1'b1; Host_R_W = rw; Host_Addr = addr; Host_WData = wd;
      end
      if (poke && c == 3) begin
        Host_Start = 1'b1; Host_R_W = ~rw; Host_Addr = addr ^ 7'h55; Host_WData = ~wd;
      end
      if (stray && trig_c >= 0 && c == trig_c) begin
        ENG_Done = 1'b1; ENG_RData = 8'hEE;
      end
      if (trig_c >= 0 && c == trig_c + 1 + k) begin
        ENG_Done = 1'b1; ENG_RData = rd;
      end
    end
    Host_Start = 1'b0;
    ENG_Done = 1'b0;
    vectors++;
    if (trig_cnt !== 1 || trig_c !== exp_trig) begin
      miscompares++;
      $display("FAIL %s trigger: count %0d at cycle %0d, required 1 at cycle %0d", name, trig_cnt, trig_c, exp_trig);
    end
    vectors++;
    if (rw_addr_at_trig !== {rw, addr} || wd_at_trig !== wd) begin
      miscompares++;
      $display("FAIL %s eng_cmd: rw/addr %h wdata %h, required %h %h", name, rw_addr_at_trig, wd_at_trig, {rw, addr}, wd);
    end
    vectors++;
    if (done_cnt !== 1 || done_c !== exp_done) begin
      miscompares++;
      $display("FAIL %s host_done: count %0d at cycle %0d, required 1 at cycle %0d", name, done_cnt, done_c, exp_done);
    end
    vectors++;
    if (rd_at_done !== exp_rd || Host_RData !== exp_rd) begin
      miscompares++;
      $display("FAIL %s rdata: %h (held %h), required %h", name, rd_at_done, Host_RData, exp_rd);
    end
    vectors++;
    if (err_cnt !== int'(exp_to) || (exp_to && err_c !== exp_done)) begin
      miscompares++;
      $display("FAIL %s timeout_err: count %0d at cycle %0d, required %0d at cycle %0d", name, err_cnt, err_c, int'(exp_to), exp_done);
    end
    vectors++;
    if (busy_bad !== 0) begin
      miscompares++;
      $display("FAIL %s busy_window: %0d bad cycles, required 0", name, busy_bad);
    end
    vectors++;
    if (Timeout_Flag !== exp_flag || ENG_Addr !== addr) begin
      miscompares++;
      $display("FAIL %s sticky_hold: flag %b addr %h, required %b %h", name, Timeout_Flag, ENG_Addr, exp_flag, addr);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    Reset = 1'b1; Host_Start = 1'b0; ENG_Done = 1'b0;
    @(negedge clk);
    exp_flag = 1'b0;
    vectors++;
    if (obs_vec() !== reset_vec()) begin
      miscompares++;
      $display("FAIL reset_values: %h, required %h", obs_vec(), reset_vec());
    end
    // Request made in the first holdoff cycle waits for the whole holdoff.
    run_txn("holdoff", 1'b0, 7'h15, 8'h00, 0, 8'h5A, TB_HOLDOFF + 1, 1'b0, 1'b0);
  endtask

  task automatic test_host_read();
    run_txn("read_0F", 1'b0, 7'h0F, 8'h00, 34, 8'hA5, 1, 1'b0, 1'b1);
  endtask

  task automatic test_host_write_busy();
    run_txn("write_20", 1'b1, 7'h20, 8'h3C, 5, 8'h99, 1, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 1'b0, 7'h44, 8'h12, 100000, 8'h77, 1, 1'b0, 1'b0);
    run_txn("after_timeout", 1'b0, 7'h45, 8'h00, 2, 8'h6B, 1, 1'b0, 1'b0);
  endtask

  task automatic test_random_host();
    for (int i = 0; i < 10; i++) begin
      run_txn("random", 1'($urandom), 7'($urandom), 8'($urandom),
              int'($urandom_range(0, 60)), 8'($urandom), 1, 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_wait();
    int trig_cnt = 0, trig_c = -1, done_cnt = 0, done_c = -1;
    logic [7:0] rd_at_done = 8'h00;
    for (int c = 0; c <= 85; c++) begin
      @(negedge clk);
      if (c == 11) begin
        exp_flag = 1'b0;
        vectors++;
        if (obs_vec() !== reset_vec()) begin
          miscompares++;
          $display("FAIL midwait_reset_values: %h, required %h", obs_vec(), reset_vec());
        end
      end
      if (c >= 11 && ENG_Trigger) begin
        trig_cnt++;
        if (trig_c < 0) trig_c = c;
      end
      if (c >= 11 && Host_Done) begin
        done_cnt++;
        if (done_c < 0) begin
          done_c = c;
          rd_at_done = Host_RData;
        end
      end
      Host_Start = 1'b0;
      ENG_Done = 1'b0;
      ENG_RData = 8'($urandom);
      if (c == 0) begin
        Host_Start = 1'b1; Host_R_W = 1'b0; Host_Addr = 7'h33; Host_WData = 8'h00;
      end
      if (c == 10) Reset = 1'b1;
      if (c == 11) Reset = 1'b0;
      if (c == 12) begin
        Host_Start = 1'b1; Host_R_W = 1'b0; Host_Addr = 7'h2A; Host_WData = 8'h00;
      end
      if (c == 13 || c == 40) begin
        ENG_Done = 1'b1; ENG_RData = 8'hC3;
      end
      if (trig_c >= 0 && c == trig_c + 2) begin
        ENG_Done = 1'b1; ENG_RData = 8'h3D;
      end
    end
    vectors++;
    if (trig_cnt !== 1 || trig_c !== 11 + TB_HOLDOFF + 1) begin
      miscompares++;
      $display("FAIL midwait_holdoff: %0d triggers first at %0d, required 1 at %0d", trig_cnt, trig_c, 11 + TB_HOLDOFF + 1);
    end
    vectors++;
    if (done_cnt !== 1 || done_c !== 11 + TB_HOLDOFF + 4 || rd_at_done !== 8'h3D) begin
      miscompares++;
      $display("FAIL midwait_done: %0d dones at %0d data %h, required 1 at %0d data 3d", done_cnt, done_c, rd_at_done, 11 + TB_HOLDOFF + 4);
    end
  endtask

`ifdef SPI_SCHED_POLL_EN
  task automatic test_poll_seq();
    int npoll = 0, resp_c = -1, bad_rw = 0, host_spur = 0;
    logic [7:0] resp_d = 8'h00;
    logic [7:0] data_q[$];
    int exp_a;
    @(negedge clk);
    Reset = 1'b1;
    for (int c = 0; c <= 5 * TB_INTERVAL + 100 && npoll < 5; c++) begin
      @(negedge clk);
      if (ENG_Trigger) begin
        if (ENG_R_W !== 1'b0) bad_rw++;
        resp_c = c + 4;
        resp_d = 8'($urandom);
        data_q.push_back(resp_d);
      end
      if (Poll_Valid) begin
        exp_a = (int'(TB_BASE) + npoll % TB_COUNT) % 128;
        vectors++;
        if (Poll_Addr !== 7'(exp_a) || npoll >= data_q.size() || Poll_Data !== data_q[npoll]) begin
          miscompares++;
          $display("FAIL poll_%0d: addr %h data %h, required addr %h", npoll, Poll_Addr, Poll_Data, 7'(exp_a));
        end
        npoll++;
      end
      if (Host_Done) host_spur++;
      Reset = 1'b0;
      ENG_Done = 1'b0;
      ENG_RData = 8'($urandom);
      if (c == resp_c) begin
        ENG_Done = 1'b1; ENG_RData = resp_d;
      end
    end
    ENG_Done = 1'b0;
    vectors++;
    if (npoll !== 5 || bad_rw !== 0 || host_spur !== 0 || Poll_Overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL poll_seq: %0d polls, %0d writes, %0d host dones, overrun %b; required 5 0 0 0", npoll, bad_rw, host_spur, Poll_Overrun);
    end
  endtask

  task automatic test_back_to_back_tie();
    int ncomp = 0, resp_c = -1, second_c = -1, first_trig = -1;
    logic [6:0] trig_q[$];
    @(negedge clk);
    Reset = 1'b1;
    for (int c = 0; c <= 2 * TB_INTERVAL && ncomp < 3; c++) begin
      @(negedge clk);
      if (ENG_Trigger) begin
        trig_q.push_back(ENG_Addr);
        if (first_trig < 0) first_trig = c;
        resp_c = c + 3;
      end
      if (Host_Done && second_c < 0) second_c = c + 1;
      if (Host_Done || Poll_Valid) ncomp++;
      Reset = 1'b0;
      Host_Start = 1'b0;
      ENG_Done = 1'b0;
      ENG_RData = 8'($urandom);
      if (c == TB_INTERVAL - 1) begin
        Host_Start = 1'b1; Host_R_W = 1'b0; Host_Addr = 7'h11;
      end
      if (c == second_c) begin
        Host_Start = 1'b1; Host_R_W = 1'b0; Host_Addr = 7'h22;
      end
      if (c == resp_c) ENG_Done = 1'b1;
    end
    Host_Start = 1'b0;
    ENG_Done = 1'b0;
    vectors++;
    if (trig_q.size() !== 3 || first_trig !== TB_INTERVAL ||
        trig_q[0] !== 7'h11 || trig_q[1] !== TB_BASE || trig_q[2] !== 7'h22) begin
      miscompares++;
      $display("FAIL tie_order: %0d grants, first at %0d, required host 11, poll %h, host 22 from cycle %0d",
               trig_q.size(), first_trig, TB_BASE, TB_INTERVAL);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SPI_SCHED_POLL_EN
    test_poll_seq();
    test_back_to_back_tie();
`else
    test_host_read();
    test_host_write_busy();
    test_timeout();
    test_random_host();
    test_reset_mid_wait();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
